// File: rtl/mem_controller.sv
`default_nettype none
// ============================================================================
// Module  : mem_controller
// Brief   : One-line write-through / write-allocate buffer in front of backing
//           memory; buffer misses are flagged to the arbiter until resolved.
// Revision: 1.0
// ============================================================================
module mem_controller #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int WORD_W = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               raddr_valid,
    input  logic [ADDR_W-1:0]                  raddr,
    input  logic                               waddr_valid,
    input  logic [ADDR_W-1:0]                  waddr,
    input  logic [LINE_W-1:0]                  wdata,
    input  logic [LINE_W/8-1:0]                wmask,
    input  logic                               repair_resolved,
    output logic [WORD_W-1:0]                  rdata,
    output logic                               rdata_valid,
    output logic                               read_miss_repair,
    output logic                               write_miss_repair,
    output logic [ADDR_W-1:0]                  missed_addr,
    output logic                               ctrl_busy,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [ADDR_W-$clog2(LINE_W/8)-1:0] mem_addr,
    output logic [LINE_W-1:0]                  mem_wdata,
    output logic [LINE_W/8-1:0]                mem_wmask,
    input  logic                               mem_ready,
    input  logic                               mem_rvalid,
    input  logic [LINE_W-1:0]                  mem_rdata
);
    localparam int c_OFF_W  = $clog2(LINE_W/8);
    localparam int c_BOFF_W = $clog2(WORD_W/8);
    localparam int c_WORDS  = LINE_W / WORD_W;
    localparam int c_WSEL_W = $clog2(c_WORDS);
    localparam int c_TAG_W  = ADDR_W - c_OFF_W;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FILL_REQ    = 3'd1,
        S_FILL_WAIT   = 3'd2,
        S_RESP        = 3'd3,
        S_WR_REQ      = 3'd4,
        S_REPAIR_WAIT = 3'd5
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_buf_valid;
    logic [c_TAG_W-1:0]          r_buf_tag;
    logic [LINE_W-1:0]           r_buf_data;
    logic [c_TAG_W-1:0]          r_req_tag;
    logic [c_WSEL_W-1:0]         r_req_wsel;
    logic [LINE_W-1:0]           r_req_wdata;
    logic [LINE_W/8-1:0]         r_req_wmask;
    logic                        r_req_write;
    logic                        r_req_miss;
    logic                        r_read_miss;
    logic                        r_write_miss;
    logic [ADDR_W-1:0]           r_missed_addr;

    logic [ADDR_W-1:0]           w_in_addr;
    logic                        w_hit;
    logic                        w_accept;
    logic [c_WORDS-1:0][WORD_W-1:0] w_buf_words;

    function automatic logic [LINE_W-1:0] merge_bytes(
        input logic [LINE_W-1:0]   base,
        input logic [LINE_W-1:0]   upd,
        input logic [LINE_W/8-1:0] mask
    );
        logic [LINE_W-1:0] merged;
        merged = base;
        for (int i = 0; i < LINE_W/8; i++) begin
            if (mask[i]) merged[8*i +: 8] = upd[8*i +: 8];
        end
        return merged;
    endfunction

    // A simultaneous write wins over the read, so the write address drives the hit test.
    assign w_in_addr   = waddr_valid ? waddr : raddr;
    assign w_hit       = r_buf_valid && (r_buf_tag == w_in_addr[ADDR_W-1:c_OFF_W]);
    assign w_accept    = (r_state == S_IDLE) && (raddr_valid || waddr_valid);
    assign w_buf_words = r_buf_data;

    assign read_miss_repair  = r_read_miss;
    assign write_miss_repair = r_write_miss;
    assign missed_addr       = r_missed_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        rdata       = '0;
        rdata_valid = 1'b0;
        ctrl_busy   = (r_state != S_IDLE);
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wmask   = '0;
        case (r_state)
            S_IDLE: begin
                if (waddr_valid)      w_state_nxt = w_hit ? S_WR_REQ : S_FILL_REQ;
                else if (raddr_valid) w_state_nxt = w_hit ? S_RESP   : S_FILL_REQ;
            end
            S_FILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = r_req_tag;
                if (mem_ready) w_state_nxt = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (mem_rvalid) w_state_nxt = r_req_write ? S_WR_REQ : S_RESP;
            end
            S_RESP: begin
                rdata       = w_buf_words[r_req_wsel];
                rdata_valid = 1'b1;
                w_state_nxt = r_req_miss ? S_REPAIR_WAIT : S_IDLE;
            end
            S_WR_REQ: begin
                // An allocated line is pushed whole; a hit forwards the caller's bytes only.
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_req_tag;
                mem_wdata = r_req_miss ? r_buf_data : r_req_wdata;
                mem_wmask = r_req_miss ? '1 : r_req_wmask;
                if (mem_ready) w_state_nxt = r_req_miss ? S_REPAIR_WAIT : S_IDLE;
            end
            S_REPAIR_WAIT: begin
                if (repair_resolved) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid   <= 1'b0;
            r_buf_tag     <= '0;
            r_buf_data    <= '0;
            r_req_tag     <= '0;
            r_req_wsel    <= '0;
            r_req_wdata   <= '0;
            r_req_wmask   <= '0;
            r_req_write   <= 1'b0;
            r_req_miss    <= 1'b0;
            r_read_miss   <= 1'b0;
            r_write_miss  <= 1'b0;
            r_missed_addr <= '0;
        end else begin
            if (w_accept) begin
                r_req_tag   <= w_in_addr[ADDR_W-1:c_OFF_W];
                r_req_wsel  <= w_in_addr[c_OFF_W-1:c_BOFF_W];
                r_req_wdata <= wdata;
                r_req_wmask <= wmask;
                r_req_write <= waddr_valid;
                r_req_miss  <= !w_hit;
                if (!w_hit) begin
                    r_read_miss   <= !waddr_valid;
                    r_write_miss  <= waddr_valid;
                    r_missed_addr <= w_in_addr;
                end
                if (waddr_valid && w_hit) r_buf_data <= merge_bytes(r_buf_data, wdata, wmask);
            end
            if ((r_state == S_FILL_WAIT) && mem_rvalid) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= r_req_tag;
                r_buf_data  <= r_req_write ? merge_bytes(mem_rdata, r_req_wdata, r_req_wmask)
                                           : mem_rdata;
            end
            if ((r_state == S_REPAIR_WAIT) && repair_resolved) begin
                r_read_miss  <= 1'b0;
                r_write_miss <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_controller
// Brief   : Directed plus randomized bench; the bench plays backing memory and
//           predicts every response from a line-level memory/buffer model.
// Revision: 1.0
// ============================================================================
module tb_mem_controller;
    logic         clk = 1'b0;
    logic         rst;
    logic         raddr_valid;
    logic [31:0]  raddr;
    logic         waddr_valid;
    logic [31:0]  waddr;
    logic [255:0] wdata;
    logic [31:0]  wmask;
    logic         repair_resolved;
    logic [31:0]  rdata;
    logic         rdata_valid;
    logic         read_miss_repair;
    logic         write_miss_repair;
    logic [31:0]  missed_addr;
    logic         ctrl_busy;
    logic         mem_req;
    logic         mem_we;
    logic [26:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_wmask;
    logic         mem_ready;
    logic         mem_rvalid;
    logic [255:0] mem_rdata;

    mem_controller dut (
        .clk(clk), .rst(rst),
        .raddr_valid(raddr_valid), .raddr(raddr),
        .waddr_valid(waddr_valid), .waddr(waddr),
        .wdata(wdata), .wmask(wmask),
        .repair_resolved(repair_resolved),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .read_miss_repair(read_miss_repair), .write_miss_repair(write_miss_repair),
        .missed_addr(missed_addr), .ctrl_busy(ctrl_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: backing memory contents plus which line the buffer holds.
    logic [255:0] mem [logic [26:0]];
    bit           m_valid = 1'b0;
    logic [26:0]  m_tag   = '0;
    logic [31:0]  last_rdata;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom();
        return l;
    endfunction

    function automatic logic [255:0] apply_mask(input logic [255:0] base, input logic [255:0] upd,
                                                input logic [31:0] m);
        logic [255:0] bm;
        for (int i = 0; i < 32; i++) bm[8*i +: 8] = {8{m[i]}};
        return (base & ~bm) | (upd & bm);
    endfunction

    function automatic void ensure_line(input logic [26:0] la);
        if (!mem.exists(la)) mem[la] = rand_line();
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {rdata, rdata_valid, read_miss_repair, write_miss_repair, missed_addr,
                              ctrl_busy, mem_req, mem_we, mem_addr, mem_wmask}, '0);
        check({tag, "_wdata"}, mem_wdata, '0);
    endtask

    // One full request: drive it, act as memory, resolve the flag, check every cycle.
    task automatic transact(input bit is_wr, input logic [31:0] addr, input logic [255:0] wd,
                            input logic [31:0] wm, input bit also_rd, input logic [31:0] rd_addr,
                            input int rdy_dly, input int rv_dly, input bit early_res, input int res_dly);
        logic [26:0]  la;
        logic [255:0] old;
        logic [31:0]  exp_word;
        bit hit, miss, fill_acc, wr_acc, rv_pend, res_arm, done, ph_done, fill_phase;
        int wait_c, rv_cnt, res_cnt, n_rv, widx;
        la = addr[31:5];
        ensure_line(la);
        old  = mem[la];
        widx = int'(addr[4:2]);
        exp_word = old[32*widx +: 32];
        hit  = m_valid && (m_tag == la);
        miss = !hit;
        fill_acc = 0; wr_acc = 0; rv_pend = 0; res_arm = 0; done = 0;
        wait_c = 0; rv_cnt = 0; res_cnt = 0; n_rv = 0;

        waddr_valid = is_wr;
        waddr       = addr;
        wdata       = wd;
        wmask       = wm;
        raddr_valid = !is_wr || also_rd;
        raddr       = is_wr ? rd_addr : addr;
        repair_resolved = early_res;
        @(posedge clk); #1;
        raddr_valid = 0;
        waddr_valid = 0;
        check("busy_after_accept", ctrl_busy, 1);

        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            mem_ready  = 0;
            mem_rvalid = 0;
            if (!ctrl_busy) begin
                done = 1;
            end else begin
                check("read_miss_flag", read_miss_repair, miss && !is_wr);
                check("write_miss_flag", write_miss_repair, miss && is_wr);
                if (miss) check("missed_addr", missed_addr, addr);
                if (rdata_valid) begin
                    n_rv++;
                    last_rdata = rdata;
                    if (is_wr) check("rdata_valid_on_write", 1, 0);
                    else check("rdata", rdata, exp_word);
                    if (hit && !is_wr) check("hit_latency", cyc, 0);
                end
                if (rv_pend) begin
                    rv_cnt--;
                    if (rv_cnt <= 0) begin
                        mem_rvalid = 1;
                        mem_rdata  = old;
                        rv_pend    = 0;
                    end
                end
                if (mem_req) begin
                    fill_phase = miss && !fill_acc;
                    if (!fill_phase && (!is_wr || wr_acc)) check("unexpected_mem_req", 1, 0);
                    check("mem_we", mem_we, !fill_phase);
                    check("mem_addr", mem_addr, la);
                    if (!fill_phase) begin
                        check("mem_wdata", mem_wdata, miss ? apply_mask(old, wd, wm) : wd);
                        check("mem_wmask", mem_wmask, miss ? 32'hFFFF_FFFF : wm);
                    end
                    if (wait_c >= rdy_dly) begin
                        mem_ready = 1;
                        wait_c = 0;
                        if (fill_phase) begin
                            fill_acc = 1;
                            rv_pend  = 1;
                            rv_cnt   = rv_dly;
                        end else begin
                            wr_acc  = 1;
                            mem[la] = apply_mask(old, wd, wm);
                        end
                    end else begin
                        wait_c++;
                    end
                end
                ph_done = is_wr ? wr_acc : (n_rv > 0);
                if (miss && ph_done && !early_res) begin
                    if (!res_arm) begin
                        res_arm = 1;
                        res_cnt = res_dly;
                    end
                    if (res_cnt == 0) repair_resolved = 1;
                    else res_cnt--;
                end
                @(posedge clk); #1;
            end
        end
        mem_ready = 0;
        mem_rvalid = 0;
        repair_resolved = 0;
        if (!done) check("timeout_busy", ctrl_busy, 0);
        check("flags_clear_at_idle", {read_miss_repair, write_miss_repair, mem_req}, 0);
        check("rdata_valid_count", n_rv, is_wr ? 0 : 1);
        check("fill_issued", fill_acc, miss);
        check("write_issued", wr_acc, is_wr);
        m_valid = 1;
        m_tag   = la;
    endtask

    task automatic reset_mid_fill(input logic [31:0] addr);
        ensure_line(addr[31:5]);
        raddr_valid = 1;
        raddr       = addr;
        @(posedge clk); #1;
        raddr_valid = 0;
        check("rst_test_fill_req", mem_req, 1);
        mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0;
        check("rst_test_in_fill_wait", {ctrl_busy, mem_req, read_miss_repair}, 3'b101);
        rst = 1;
        #1;
        check_all_zero("rst_mid_fill");
        @(posedge clk); #1;
        rst = 0;
        m_valid = 0;
        @(posedge clk); #1;
        check_all_zero("after_mid_reset");
    endtask

    logic [31:0] pool [4] = '{32'h0000_1000, 32'h0000_1020, 32'h0000_2000, 32'h0000_3000};

    initial begin
        logic [255:0] line;
        logic [255:0] wd;
        logic [31:0]  a, ra, wm;
        bit           wr;

        rst = 1;
        raddr_valid = 0; raddr = '0; waddr_valid = 0; waddr = '0;
        wdata = '0; wmask = '0; repair_resolved = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 0;
        @(posedge clk); #1;

        // Read miss then hit on the neighbouring word.
        line = rand_line();
        line[63:32] = 32'hDEAD_BEEF;
        mem[27'h82] = line;
        transact(0, 32'h0000_1044, '0, '0, 0, '0, 2, 3, 0, 3);
        check("t1_rdata", last_rdata, 32'hDEAD_BEEF);
        transact(0, 32'h0000_1048, '0, '0, 0, '0, 0, 1, 0, 0);
        check("t2_rdata", last_rdata, line[95:64]);

        // Write hit on word 0, then read it back.
        wd = rand_line();
        wd[31:0] = 32'h1234_5678;
        transact(1, 32'h0000_1040, wd, 32'h0000_000F, 0, '0, 1, 1, 0, 0);
        transact(0, 32'h0000_1040, '0, '0, 0, '0, 0, 1, 0, 0);
        check("t3_readback", last_rdata, 32'h1234_5678);

        // Write miss allocating an all-0xAA line with the top word replaced.
        mem[27'h100] = {32{8'hAA}};
        wd = rand_line();
        transact(1, 32'h0000_2000, wd, 32'hF000_0000, 0, '0, 1, 2, 0, 1);
        check("t4_mem_line", mem[27'h100], {wd[255:224], {28{8'hAA}}});

        // Simultaneous read and write: only the write happens.
        transact(1, 32'h0000_2000, rand_line(), $urandom(), 1, 32'h0000_2004, 0, 1, 0, 0);

        // Zero-mask writes: hit and miss.
        transact(1, 32'h0000_2000, rand_line(), 32'h0, 0, '0, 0, 1, 0, 0);
        transact(1, 32'h0000_3000, rand_line(), 32'h0, 0, '0, 1, 1, 1, 0);

        // Reset during a fill, then the same line must miss again.
        reset_mid_fill(32'h0000_1024);
        transact(0, 32'h0000_1024, '0, '0, 0, '0, 0, 1, 0, 2);

        for (int t = 0; t < 60; t++) begin
            a  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
            ra = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
            wr = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       wm = 32'h0;
                1:       wm = 32'hFFFF_FFFF;
                default: wm = $urandom();
            endcase
            transact(wr, a, rand_line(), wm, wr && ($urandom_range(0, 3) == 0), ra,
                     $urandom_range(0, 3), $urandom_range(1, 3),
                     ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
